// File: rtl/round_judge.sv
// rtl/round_judge.sv - round referee: button sync/edge detect, round decision, rope position, match end (option macro ROUND_JUDGE_FOUL_EN)
module round_judge #(
    parameter int WIN_POS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pa,
    input  logic              pb,
    input  logic              clear,
    input  logic              leds_on,
    output logic              winrnd,
    output logic              winner,
    output logic signed [3:0] pos,
    output logic              match_over
);

    localparam logic signed [3:0] WIN_P = 4'(WIN_POS);
    localparam logic signed [3:0] WIN_N = -WIN_P;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DECIDED = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic       hist_a;
    logic       hist_b;
    logic       press_a;
    logic       press_b;

    logic              dec_valid;
    logic              dec_winner;
    logic signed [3:0] pos_step;
    logic              pos_hit;

    // Two-flop synchronisers plus a history flop per button; a press is one rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
            hist_a <= 1'b0;
            hist_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[0], pa};
            sync_b <= {sync_b[0], pb};
            hist_a <= sync_a[1];
            hist_b <= sync_b[1];
        end
    end

    assign press_a = sync_a[1] & ~hist_a;
    assign press_b = sync_b[1] & ~hist_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dec_valid  = 1'b0;
        dec_winner = winner;
        pos_step   = pos;
        pos_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (!clear) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                // clear takes priority: a round that is no longer armed cannot be decided
                if (clear) begin
                    state_nxt = IDLE;
                end else if (press_a ^ press_b) begin
                    if (leds_on) begin
                        dec_valid  = 1'b1;
                        dec_winner = press_b;
                    end
`ifdef ROUND_JUDGE_FOUL_EN
                    else begin
                        dec_valid  = 1'b1;
                        dec_winner = press_a;
                    end
`endif
                end
                if (dec_valid) begin
                    pos_step  = dec_winner ? (pos - 4'sd1) : (pos + 4'sd1);
                    pos_hit   = (pos_step == WIN_P) || (pos_step == WIN_N);
                    state_nxt = pos_hit ? OVER : DECIDED;
                end
            end
            DECIDED: begin
                if (clear) begin
                    state_nxt = IDLE;
                end
            end
            OVER: begin
                state_nxt = OVER;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winrnd     <= 1'b0;
            winner     <= 1'b0;
            pos        <= 4'sd0;
            match_over <= 1'b0;
        end else begin
            winrnd <= dec_valid;
            if (dec_valid) begin
                winner <= dec_winner;
                pos    <= pos_step;
                if (pos_hit) begin
                    match_over <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_round_judge.sv
// tb/tb_round_judge.sv - table-driven and randomized checks of round_judge against a round-level model
module tb_round_judge;

    localparam int WIN_POS = 4;
`ifdef ROUND_JUDGE_FOUL_EN
    localparam bit FOUL = 1'b1;
`else
    localparam bit FOUL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              pa;
    logic              pb;
    logic              clear;
    logic              leds_on;
    logic              winrnd;
    logic              winner;
    logic signed [3:0] pos;
    logic              match_over;

    round_judge #(.WIN_POS(WIN_POS)) dut (
        .clk        (clk),
        .rst        (rst),
        .pa         (pa),
        .pb         (pb),
        .clear      (clear),
        .leds_on    (leds_on),
        .winrnd     (winrnd),
        .winner     (winner),
        .pos        (pos),
        .match_over (match_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic pa;
        logic pb;
        logic clear;
        logic leds;
        logic exp_winrnd;
        logic exp_winner;
        int   exp_pos;
        logic exp_match;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Round-level reference: pin sample history plus round phase and score
    logic qa[$];
    logic qb[$];
    int   m_phase;   // 0 waiting for arm, 1 armed, 2 decided, 3 match over
    int   m_pos;
    logic m_winrnd;
    logic m_winner;
    logic m_match;

    task automatic model_step(input logic r, input logic a, input logic b, input logic c, input logic l);
        logic pr_a;
        logic pr_b;
        logic a_wins;
        if (r) begin
            m_phase  = 0;
            m_pos    = 0;
            m_winrnd = 1'b0;
            m_winner = 1'b0;
            m_match  = 1'b0;
            qa = '{1'b0, 1'b0, 1'b0};
            qb = '{1'b0, 1'b0, 1'b0};
            return;
        end
        pr_a = qa[1] & ~qa[0];
        pr_b = qb[1] & ~qb[0];
        qa.push_back(a);
        void'(qa.pop_front());
        qb.push_back(b);
        void'(qb.pop_front());
        m_winrnd = 1'b0;
        case (m_phase)
            0: if (!c) m_phase = 1;
            1: begin
                if (c) begin
                    m_phase = 0;
                end else if ((pr_a != pr_b) && (l || FOUL)) begin
                    a_wins   = l ? pr_a : pr_b;
                    m_pos    = m_pos + (a_wins ? 1 : -1);
                    m_winner = ~a_wins;
                    m_winrnd = 1'b1;
                    if (m_pos == WIN_POS || m_pos == -WIN_POS) begin
                        m_match = 1'b1;
                        m_phase = 3;
                    end else begin
                        m_phase = 2;
                    end
                end
            end
            2: if (c) m_phase = 0;
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic a, input logic b, input logic c, input logic l);
        @(negedge clk);
        rst     = r;
        pa      = a;
        pb      = b;
        clear   = c;
        leds_on = l;
        @(posedge clk);
        model_step(r, a, b, c, l);
        cyc++;
        #1;
    endtask

    task automatic add(input logic r, input logic a, input logic b, input logic c, input logic l,
                       input logic w, input logic wn, input int p, input logic m);
        vec_t v;
        v.rst = r; v.pa = a; v.pb = b; v.clear = c; v.leds = l;
        v.exp_winrnd = w; v.exp_winner = wn; v.exp_pos = p; v.exp_match = m;
        vecs.push_back(v);
    endtask

    task automatic build_table();
        // A wins on GO; held button never re-triggers
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) add(0, 1, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        // Simultaneous edges tie, then a lone B edge wins
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 1, -1, 0);
        add(0, 0, 1, 1, 0, 0, 1, -1, 0);
        add(0, 0, 0, 1, 0, 0, 1, -1, 0);
        add(0, 0, 0, 1, 0, 0, 1, -1, 0);
        // A press while dark: foul gives B the round only when the option is built in
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, FOUL, FOUL, FOUL ? -1 : 0, 0);
        add(0, 1, 0, 1, 0, 0, FOUL, FOUL ? -1 : 0, 0);
        add(0, 0, 0, 1, 0, 0, FOUL, FOUL ? -1 : 0, 0);
        // Four A rounds end the match; a fifth press is absorbed
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int r = 1; r <= 5; r++) begin
            int p;
            p = (r > WIN_POS) ? WIN_POS : r - 1;
            add(0, 0, 0, 0, 1, 0, 0, p, (r > WIN_POS));
            add(0, 1, 0, 0, 1, 0, 0, p, (r > WIN_POS));
            add(0, 1, 0, 0, 1, 0, 0, p, (r > WIN_POS));
            p = (r > WIN_POS) ? WIN_POS : r;
            add(0, 1, 0, 0, 1, (r <= WIN_POS), 0, p, (r >= WIN_POS));
            add(0, 0, 0, 1, 0, 0, 0, p, (r >= WIN_POS));
            add(0, 0, 0, 1, 0, 0, 0, p, (r >= WIN_POS));
        end
        // Reset one cycle after the pin edge abandons the round; held button stays silent
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0, 0, 0, 1, 0);
    endtask

    initial begin
        logic r, a, b, c, l, prev_w;
        rst = 1'b1; pa = 1'b0; pb = 1'b0; clear = 1'b1; leds_on = 1'b0;
        model_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        build_table();

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].pa, vecs[i].pb, vecs[i].clear, vecs[i].leds);
            check("tbl_winrnd", winrnd, vecs[i].exp_winrnd);
            check("tbl_winner", winner, vecs[i].exp_winner);
            check("tbl_pos", pos, vecs[i].exp_pos);
            check("tbl_match", match_over, vecs[i].exp_match);
        end

        r = 1'b1; a = 1'b0; b = 1'b0; c = 1'b1; l = 1'b0; prev_w = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) a = ~a;
            if ($urandom_range(3) == 0) b = ~b;
            if ($urandom_range(9) == 0) c = ~c;
            if ($urandom_range(5) == 0) l = ~l;
            cycle(r, a, b, c, l);
            check("rnd_winrnd", winrnd, m_winrnd);
            check("rnd_winner", winner, m_winner);
            check("rnd_pos", pos, m_pos);
            check("rnd_match", match_over, m_match);
            check("rnd_no_double_pulse", winrnd & prev_w, 0);
            prev_w = winrnd;
            r = ($urandom_range(299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
